// File: rtl/kf6845_cursor_array.sv
// Multi-cursor unit for the KF6845 CRTC: per-cursor address/scanline/blink compare, skewed CURSOR output.
// Optional tear-free shadow registers: define KF6845_CURSOR_SHADOW_EN.
module kf6845_cursor_array #(
    parameter int unsigned CURSOR_COUNT = 2,
    parameter int unsigned MA_WIDTH     = 14,
    parameter int unsigned RA_WIDTH     = 5,
    parameter int unsigned CURSOR_SKEW  = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    video_clock_enable,
    input  logic [7:0]              internal_data_bus_in,
    output logic [7:0]              internal_data_bus_out,
    input  logic [1:0]              cursor_select,
    input  logic                    write_cursor_start_register,
    input  logic                    write_cursor_end_register,
    input  logic                    write_cursor_h_register,
    input  logic                    write_cursor_l_register,
    input  logic                    read_cursor_h_register,
    input  logic                    read_cursor_l_register,
    input  logic                    V_total,
    input  logic                    display_enable,
    input  logic [RA_WIDTH-1:0]     RA,
    input  logic [MA_WIDTH-1:0]     MA,
    output logic                    CURSOR,
    output logic [CURSOR_COUNT-1:0] cursor_hit
);

    localparam int unsigned STAGES = CURSOR_SKEW + 1;
    localparam int unsigned HI_W   = MA_WIDTH - 8;
    localparam int unsigned PIPE_W = STAGES * CURSOR_COUNT;

    logic [4:0]              blink_q, blink_d;
    logic [CURSOR_COUNT-1:0] raw_hit;
    logic [7:0]              rd_chain [CURSOR_COUNT+1];
    logic [PIPE_W-1:0]       pipe_q, pipe_d;
    logic                    cursor_q;

    // Field counter driving the blink phases
    always_comb begin
        blink_d = blink_q;
        if (V_total) blink_d = blink_q + 5'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blink_q <= 5'd0;
        else          blink_q <= blink_d;
    end

    assign rd_chain[0] = 8'h00;

    for (genvar i = 0; i < int'(CURSOR_COUNT); i++) begin : gen_cursor
        logic                sel;
        logic [MA_WIDTH-1:0] addr_q, addr_d, cmp_addr;
        logic [6:0]          start_q, start_d, cmp_start;
        logic [4:0]          end_q, end_d, cmp_end;
        logic [RA_WIDTH-1:0] line_s, line_e;
        logic                line_ok, visible;
        logic [7:0]          rd_part;

        assign sel = (cursor_select == 2'(i));

        always_comb begin
            addr_d  = addr_q;
            start_d = start_q;
            end_d   = end_q;
            if (sel) begin
                if (write_cursor_start_register) start_d = internal_data_bus_in[6:0];
                if (write_cursor_end_register)   end_d   = internal_data_bus_in[4:0];
                if (write_cursor_h_register)     addr_d[MA_WIDTH-1:8] = internal_data_bus_in[HI_W-1:0];
                if (write_cursor_l_register)     addr_d[7:0] = internal_data_bus_in;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                addr_q  <= '0;
                start_q <= '0;
                end_q   <= '0;
            end else begin
                addr_q  <= addr_d;
                start_q <= start_d;
                end_q   <= end_d;
            end
        end

`ifdef KF6845_CURSOR_SHADOW_EN
        // Compare copies only change at field end so a half-written cursor never shows
        logic [MA_WIDTH-1:0] sh_addr_q;
        logic [6:0]          sh_start_q;
        logic [4:0]          sh_end_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sh_addr_q  <= '0;
                sh_start_q <= '0;
                sh_end_q   <= '0;
            end else if (V_total) begin
                sh_addr_q  <= addr_q;
                sh_start_q <= start_q;
                sh_end_q   <= end_q;
            end
        end

        assign cmp_addr  = sh_addr_q;
        assign cmp_start = sh_start_q;
        assign cmp_end   = sh_end_q;
`else
        assign cmp_addr  = addr_q;
        assign cmp_start = start_q;
        assign cmp_end   = end_q;
`endif

        assign line_s = cmp_start[RA_WIDTH-1:0];
        assign line_e = cmp_end[RA_WIDTH-1:0];

        // Start above end means a split cursor covering the top and bottom of the cell
        assign line_ok = (line_s <= line_e) ? ((RA >= line_s) && (RA <= line_e))
                                            : ((RA >= line_s) || (RA <= line_e));

        always_comb begin
            visible = 1'b1;
            case (cmp_start[6:5])
                2'b00: visible = 1'b1;
                2'b01: visible = 1'b0;
                2'b10: visible = ~blink_q[3];
                2'b11: visible = ~blink_q[4];
                default: visible = 1'b1;
            endcase
        end

        assign raw_hit[i] = (MA == cmp_addr) & line_ok & visible & display_enable;

        // High byte wins when both read strobes are asserted
        always_comb begin
            rd_part = 8'h00;
            if (sel && read_cursor_h_register)      rd_part = 8'(addr_q[MA_WIDTH-1:8]);
            else if (sel && read_cursor_l_register) rd_part = addr_q[7:0];
        end

        assign rd_chain[i+1] = rd_chain[i] | rd_part;
    end

    assign internal_data_bus_out = rd_chain[CURSOR_COUNT];

    // Shift register of hit vectors, newest in the low slot
    if (STAGES == 1) begin : gen_no_skew
        assign pipe_d = raw_hit;
    end else begin : gen_skew
        assign pipe_d = {pipe_q[PIPE_W-CURSOR_COUNT-1:0], raw_hit};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q   <= '0;
            cursor_q <= 1'b0;
        end else if (video_clock_enable) begin
            pipe_q   <= pipe_d;
            cursor_q <= |pipe_d[PIPE_W-1 -: CURSOR_COUNT];
        end
    end

    assign cursor_hit = pipe_q[PIPE_W-1 -: CURSOR_COUNT];
    assign CURSOR     = cursor_q;

endmodule

// File: doc/kf6845_cursor_array.md
Name: kf6845_cursor_array

Overview:
- Parametrised successor to the single-cursor unit of the KF6845 CRTC.
- Holds CURSOR_COUNT independent cursors, each with its own:
  - address register,
  - start/end scanline register,
  - blink mode.
- Compares all cursors against the live MA/RA stream, supports split (wrap-around) scanline ranges and a programmable output skew, and ORs the hits onto CURSOR.
- Sits beside the CRTC horizontal/vertical counters; registers are written over the internal data bus.

Parameters:
- CURSOR_COUNT, 2, number of cursors (1..4).
- MA_WIDTH, 14, memory-address width (9..16).
- RA_WIDTH, 5, row-address width (1..5).
- CURSOR_SKEW, 0, extra character-clock delay stages on the cursor output (0..3).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- video_clock_enable  in  1  character-clock enable
- internal_data_bus_in  in  8  write data
- internal_data_bus_out  out  8  read data
- cursor_select  in  2  cursor index for all register accesses
- write_cursor_start_register  in  1  write start register: [6:5] mode, [4:0] start line
- write_cursor_end_register  in  1  write end register: [4:0] end line
- write_cursor_h_register  in  1  write address high byte
- write_cursor_l_register  in  1  write address low byte
- read_cursor_h_register  in  1  read address high byte
- read_cursor_l_register  in  1  read address low byte
- V_total  in  1  one-clock pulse at end of field
- display_enable  in  1  active display area
- RA  in  RA_WIDTH  current row address
- MA  in  MA_WIDTH  current memory address
- CURSOR  out  1  combined cursor output
- cursor_hit  out  CURSOR_COUNT  per-cursor output, aligned with CURSOR

Behaviour:
- Reset: clock and reset are fixed as one clock; reset is asynchronous and active-low.
  - While reset_n=0, every register, the blink counter and all pipeline stages clear to 0.
  - CURSOR=0 and cursor_hit=0 during reset.
  - Reset mid-frame aborts output immediately (asynchronous).
- Register writes take effect on the clock edge where the strobe is high, for cursor index cursor_select.
  - If cursor_select >= CURSOR_COUNT, the write is ignored.
  - Start register stores data[6:0]. End register stores data[4:0].
  - H register stores data[MA_WIDTH-9:0]; higher data bits are discarded. L register stores data[7:0].
  - Simultaneous strobes to different registers are all applied in the same cycle.
- Reads are combinational:
  - read_cursor_h_register: zero-extended address[MA_WIDTH-1:8].
  - read_cursor_l_register: address[7:0].
  - Both strobes high: H takes priority.
  - No strobe, or cursor_select >= CURSOR_COUNT: 8'h00.
  - A read in the same cycle as a write to the same register returns the old value.
  - Start/end registers are write-only.
- Blink counter:
  - 5-bit, increments on every clock with V_total=1, wraps 31->0.
  - Modes and visibility:
    - 00: always visible.
    - 01: never visible.
    - 10: visible when counter[3]=0 (16-field period).
    - 11: visible when counter[4]=0 (32-field period).
- Line match (per cursor, start S, end E, compared against low RA_WIDTH bits):
  - If S<=E: S<=RA<=E.
  - If S>E: RA>=S or RA<=E (split cursor).
- raw_hit[i] = (MA==address[i]) & line_match & visible & display_enable.
- Output pipeline:
  - Stage 0 registers raw_hit when video_clock_enable=1, then CURSOR_SKEW further stages.
  - Every stage advances only on video_clock_enable.
  - Latency: 1+CURSOR_SKEW enabled clocks.
  - CURSOR = OR of the final-stage cursor_hit.
  - The stage holds its value while video_clock_enable=0.

Optional Feature:
- Macro: KF6845_CURSOR_SHADOW_EN.
- Defined:
  - Writes go to staging registers, and readback returns the staging value.
  - Compare/visibility logic uses shadow copies, which load from staging on V_total=1.
  - A write coinciding with V_total is captured into staging and is not shadowed until the next V_total.
  - This makes updates tear-free.
- Undefined: there are no shadow registers, and writes affect comparison on the next clock.

Test Plan:
- Reset, then hold reset_n=1 with defaults: MA=0, RA=0, display_enable=1 -> CURSOR=1 after 1 enabled clock; reset_n=0 mid-hit -> CURSOR=0 immediately.
- Cursor 0: start 8'h01, end 8'h0A, address 0x0F12; sweep MA {0x0F11,0x0F12,0x0F13} x RA 0..31 -> CURSOR=1 only at MA=0x0F12, RA 1..10; cursor_hit=2'b01.
- Cursor 1: start 8'h0C, end 8'h02, address 0x0100; sweep RA 0..31 -> hit at RA 0..2 and 12..31; readback H=8'h01, L=8'h00; cursor_select=3 reads 8'h00.
- Blink mode 8'h41: hold match for 64 V_total pulses -> visible 8 fields / hidden 8 fields; mode 8'h61 -> 16/16; mode 8'h21 -> never.
- CURSOR_SKEW=2 with video_clock_enable toggling every other clock -> CURSOR trails raw match by 3 enabled clocks (6 clocks).
- With KF6845_CURSOR_SHADOW_EN: write address 0x0F13 mid-field -> output still follows 0x0F12 until the V_total pulse, then 0x0F13; readback shows 0x13 immediately.
